mult_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 16x8 shift-add multiplier (mult) between N requesters.
- Accepts operand requests and latches the operands of the winner.
- Drives the multiplier's enable/a/b and holds the operands stable for the whole multiply.
- Detects completion, then returns the 24-bit product tagged with the requester ID.

---
 rtl/mult_arbiter.sv | 128 ++++++++++++
 tb/tb_mult_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one 16x8 shift-add multiplier among N requesters; done 11 cycles after ack.
// Requesters hold req until ack; optional watchdog under MULT_ARB_TIMEOUT_EN; state moves on the falling edge like mult.
module mult_arbiter #(
  parameter int N       = 4,
  parameter int ID_W    = $clog2(N),
  parameter int TIMEOUT = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*16-1:0] a_in,
  input  logic [N*8-1:0]  b_in,
  output logic [N-1:0]    ack,
  output logic            done,
  output logic [ID_W-1:0] resp_id,
  output logic [23:0]     resp_result,
  output logic            mult_enable,
  output logic [15:0]     mult_a,
  output logic [7:0]      mult_b,
  input  logic            mult_busy,
  input  logic            mult_finish,
  input  logic [23:0]     mult_result,
  output logic            err
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND} state_t;

  state_t          state;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] pick;
  logic [15:0]     a_arr [N];
  logic [7:0]      b_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign a_arr[i] = a_in[i*16 +: 16];
    assign b_arr[i] = b_in[i*8 +: 8];
  end

  // Nearest requester above ptr wins; the downward scan leaves the closest one assigned last.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0] r, input logic [ID_W-1:0] ptr);
    logic [ID_W-1:0] idx;
    rr_pick = ptr;
    for (int k = N; k >= 1; k--) begin
      idx = ID_W'((int'(ptr) + k) % N);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign pick = rr_pick(req, last);

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] wd_cnt;
`else
  // Without the watchdog TIMEOUT has no effect.
  assign err = 1'b0 && (TIMEOUT != 0);
`endif

  always_ff @(negedge clock) begin
    if (reset) begin
      state       <= IDLE;
      last        <= ID_W'(N - 1);
      ack         <= '0;
      done        <= 1'b0;
      mult_enable <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
      mult_a      <= '0;
      mult_b      <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      err         <= 1'b0;
      wd_cnt      <= '0;
`endif
    end else begin
      ack         <= '0;
      done        <= 1'b0;
      mult_enable <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
      err         <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            last   <= pick;
            ack    <= N'(1) << pick;
            mult_a <= a_arr[pick];
            mult_b <= b_arr[pick];
            state  <= ISSUE;
`ifdef MULT_ARB_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end
        end
        ISSUE: begin
          mult_enable <= 1'b1;
          state       <= WAIT_BUSY;
        end
        // finish may still be high from the previous op until busy rises
        WAIT_BUSY: begin
          if (mult_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!mult_busy && mult_finish) begin
            resp_result <= mult_result;
            state       <= RESPOND;
          end
        end
        RESPOND: begin
          done    <= 1'b1;
          resp_id <= last;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef MULT_ARB_TIMEOUT_EN
      if (state inside {WAIT_BUSY, WAIT_DONE}) begin
        wd_cnt <= wd_cnt + 1'b1;
        if (wd_cnt == TO_W'(TIMEOUT - 1)) begin
          err     <= 1'b1;
          resp_id <= last;
          state   <= IDLE;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural 8-iteration multiplier plus a scoreboard of expected responses.
module tb_mult_arbiter;
  localparam int N    = 4;
  localparam int ID_W = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*16-1:0] a_in;
  logic [N*8-1:0]  b_in;
  logic [N-1:0]    ack;
  logic            done;
  logic [ID_W-1:0] resp_id;
  logic [23:0]     resp_result;
  logic            mult_enable;
  logic [15:0]     mult_a;
  logic [7:0]      mult_b;
  logic            mult_busy;
  logic            mult_finish;
  logic [23:0]     mult_result;
  logic            err;

  mult_arbiter #(
    .N(N)
`ifdef MULT_ARB_TIMEOUT_EN
    , .TIMEOUT(5)
`endif
  ) dut (
    .clock(clock), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .done(done), .resp_id(resp_id), .resp_result(resp_result),
    .mult_enable(mult_enable), .mult_a(mult_a), .mult_b(mult_b),
    .mult_busy(mult_busy), .mult_finish(mult_finish), .mult_result(mult_result),
    .err(err)
  );

  always #5 clock = ~clock;

  // multiplier model: busy from the edge after enable, 8 iterations, sticky finish
  logic m_busy_r;
  logic stuck_busy = 1'b0;
  int   m_iter;
  assign mult_busy = m_busy_r | stuck_busy;

  always @(negedge clock) begin
    if (reset) begin
      m_busy_r    <= 1'b0;
      mult_finish <= 1'b0;
      mult_result <= '0;
      m_iter      <= 0;
    end else if (mult_enable) begin
      m_busy_r    <= 1'b1;
      mult_finish <= 1'b0;
      m_iter      <= 1;
    end else if (m_busy_r) begin
      if (m_iter == 7) begin
        m_busy_r    <= 1'b0;
        mult_finish <= 1'b1;
        mult_result <= 24'(mult_a) * 24'(mult_b);
      end else begin
        m_iter <= m_iter + 1;
      end
    end
  end

  typedef struct {
    int          id;
    logic [23:0] res;
    int          ack_cyc;
  } exp_t;

  exp_t        sb[$];
  int          grants[$];
  int          done_cycles[$];
  logic [23:0] res_log[$];
  int          cyc = 0;
  int          m_last = N - 1;
  int          last_ack_cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
`ifdef MULT_ARB_TIMEOUT_EN
  int          err_cyc = -1;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rr_model(input logic [N-1:0] r, input int ptr);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (ptr + k) % N;
      if (((r >> idx) & N'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  task automatic set_ops(input int i, input logic [15:0] a, input logic [7:0] b);
    a_in[i*16 +: 16] = a;
    b_in[i*8 +: 8]   = b;
  endtask

  // One cycle: sample on the rising edge (DUT moves on the falling edge), then react.
  task automatic tick();
    exp_t e;
    int   p;
    @(posedge clock);
    cyc++;
    if (ack !== '0) begin
      p = rr_model(req, m_last);
      check("ack_winner", 32'(ack), (p >= 0) ? (32'd1 << p) : 32'd0);
      if (p >= 0) begin
        m_last = p;
        grants.push_back(p);
        e.id      = p;
        e.res     = 24'(a_in[p*16 +: 16]) * 24'(b_in[p*8 +: 8]);
        e.ack_cyc = cyc;
        sb.push_back(e);
        last_ack_cyc = cyc;
      end
      req = req & ~ack;
    end
    if (mult_enable) begin
      if (sb.size() == 0) check("enable_unexpected", 32'd1, 32'd0);
      else check("enable_after_ack", 32'(cyc - sb[$].ack_cyc), 32'd1);
    end
    if (done) begin
      if (sb.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("resp_id", 32'(resp_id), 32'(e.id));
        check("resp_result", 32'(resp_result), 32'(e.res));
        check("done_latency", 32'(cyc - e.ack_cyc), 32'd11);
      end
      done_cycles.push_back(cyc);
      res_log.push_back(resp_result);
    end
    if (err) begin
`ifdef MULT_ARB_TIMEOUT_EN
      if (sb.size() == 0) begin
        check("err_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("err_id", 32'(resp_id), 32'(e.id));
      end
      err_cyc = cyc;
`else
      check("err_tied_low", 32'(err), 32'd0);
`endif
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || req != '0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    req    = '0;
    sb.delete();
    m_last = N - 1;
    tick();
    tick();
    reset  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    reset = 1'b1;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clock);
    tick();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_enable", 32'(mult_enable), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_resp_result", 32'(resp_result), 32'd0);
    check("rst_mult_a", 32'(mult_a), 32'd0);
    check("rst_mult_b", 32'(mult_b), 32'd0);

    // single request from requester 0
    reset = 1'b0;
    set_ops(0, 16'h1234, 8'h56);
    req = 4'b0001;
    run_until_idle(40);
    check("t1_grant", 32'(grants.size() > 0 ? grants[0] : -1), 32'd0);
    check("t1_result", 32'(res_log.size() > 0 ? res_log[$] : 24'hx), 32'h061D78);

    // all four at once after reset: rotation 0,1,2,3 at 12-cycle spacing
    do_reset();
    grants.delete();
    done_cycles.delete();
    set_ops(0, 16'h0003, 8'h07);
    set_ops(1, 16'h1000, 8'h10);
    set_ops(2, 16'hABCD, 8'h02);
    set_ops(3, 16'h8001, 8'h80);
    req = 4'b1111;
    run_until_idle(100);
    check("t2_ngrants", 32'(grants.size()), 32'd4);
    for (int i = 0; i < grants.size() && i < 4; i++) check("t2_grant_order", 32'(grants[i]), 32'(i));
    for (int i = 1; i < done_cycles.size() && i < 4; i++)
      check("t2_done_spacing", 32'(done_cycles[i] - done_cycles[i-1]), 32'd12);

    // requester 2 alone, then 0 and 2 together: 0 must win before 2
    grants.delete();
    req = 4'b0100;
    run_until_idle(40);
    req = 4'b0101;
    run_until_idle(60);
    check("t3_ngrants", 32'(grants.size()), 32'd3);
    if (grants.size() == 3) begin
      check("t3_first", 32'(grants[0]), 32'd2);
      check("t3_second", 32'(grants[1]), 32'd0);
      check("t3_third", 32'(grants[2]), 32'd2);
    end

    // operand extremes, back to back (second op sees a stale finish)
    res_log.delete();
    set_ops(0, 16'hFFFF, 8'hFF);
    set_ops(1, 16'h0000, 8'hAB);
    req = 4'b0011;
    run_until_idle(60);
    check("t4_nres", 32'(res_log.size()), 32'd2);
    if (res_log.size() == 2) begin
      check("t4_max", 32'(res_log[0]), 32'hFEFF01);
      check("t4_zero", 32'(res_log[1]), 32'h000000);
    end

    // reset while in WAIT_DONE aborts without a response
    grants.delete();
    set_ops(0, 16'h0101, 8'h03);
    req = 4'b0001;
    n = 0;
    while (grants.size() == 0 && n < 30) begin
      tick();
      n++;
    end
    check("t5_ack_seen", 32'(grants.size()), 32'd1);
    repeat (6) tick();
    reset  = 1'b1;
    req    = '0;
    sb.delete();
    m_last = N - 1;
    tick();
    check("t5_done_low", 32'(done), 32'd0);
    check("t5_enable_low", 32'(mult_enable), 32'd0);
    tick();
    reset = 1'b0;
    done_cycles.delete();
    repeat (15) tick();
    check("t5_no_done", 32'(done_cycles.size()), 32'd0);
    grants.delete();
    res_log.delete();
    set_ops(1, 16'h00FF, 8'h02);
    req = 4'b0010;
    run_until_idle(40);
    check("t5_grant_after", 32'(grants.size() > 0 ? grants[0] : -1), 32'd1);
    check("t5_result_after", 32'(res_log.size() > 0 ? res_log[0] : 24'hx), 32'h0001FE);

`ifdef MULT_ARB_TIMEOUT_EN
    // watchdog: busy stuck high
    stuck_busy = 1'b1;
    done_cycles.delete();
    set_ops(0, 16'h0002, 8'h02);
    req = 4'b0001;
    n = 0;
    while (err_cyc < 0 && n < 40) begin
      tick();
      n++;
    end
    check("t6_err_seen", 32'(err_cyc >= 0), 32'd1);
    check("t6_err_latency", 32'(err_cyc - last_ack_cyc), 32'd6);
    stuck_busy = 1'b0;
    repeat (20) tick();
    check("t6_no_done", 32'(done_cycles.size()), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
